// File: rtl/sync_fifo_if.sv
// Request/status bundle between a same-clock producer/consumer and sync_fifo.
// The master drives en/requests/write data; the FIFO (slave) returns read data, occupancy and flags.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 10
);
  logic                  en;
  logic                  wr_req;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_BITS:0]    usedw;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output en, wr_req, rd_req, data_in,
    input  data_out, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );

  modport slave (
    input  en, wr_req, rd_req, data_in,
    output data_out, full, empty, almost_full, almost_empty, usedw, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/almost flags, usedw and sticky overflow/underflow; reads take 1 cycle,
// or 0 with FIFO_FWFT_EN defined (head word shown combinationally); writes to a full FIFO pass only alongside a read.
module sync_fifo #(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 1024,
  parameter int ADDR_BITS     = 10,
  parameter int AFULL_THRESH  = 768,
  parameter int AEMPTY_THRESH = 256
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_nxt;
  logic                 full_q;
  logic                 empty_q;
  logic                 afull_q;
  logic                 aempty_q;
  logic                 ovf_q;
  logic                 udf_q;
  logic                 rd_acc;
  logic                 wr_acc;
  logic                 wr_rej;
  logic                 rd_rej;

  // An empty FIFO never bypasses: a same-cycle write is stored, the read is refused.
  always_comb begin
    rd_acc    = bus.en & bus.rd_req & ~empty_q;
    wr_acc    = bus.en & bus.wr_req & (~full_q | rd_acc);
    wr_rej    = bus.en & bus.wr_req & ~wr_acc;
    rd_rej    = bus.en & bus.rd_req & ~rd_acc;
    count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
  end

  // Flags come from count_nxt so they move in the same cycle as usedw.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_BITS'(1);
      count    <= count_nxt;
      full_q   <= (count_nxt == DEPTH_C);
      empty_q  <= (count_nxt == '0);
      afull_q  <= (count_nxt >= AFULL_C);
      aempty_q <= (count_nxt <= AEMPTY_C);
      if (wr_rej) ovf_q <= 1'b1;
      if (rd_rej) udf_q <= 1'b1;
    end
  end

  // Storage has no reset so it can map onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= bus.data_in;
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = mem[rd_ptr];
`else
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= mem[rd_ptr];
    end
  end

  assign bus.data_out = data_q;
`endif

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.usedw        = count;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo (depth 8): queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with occasional resets.
module tb_sync_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AB    = 3;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst;

  sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

  sync_fifo #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_BITS    (AB),
    .AFULL_THRESH (AF),
    .AEMPTY_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] q[$];
  bit            ov_m;
  bit            un_m;
  logic [DW-1:0] dout_m;
  bit            model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the sticky error bits.
  always @(posedge clk) begin
    bit r_ok;
    bit w_ok;
    if (rst) begin
      q.delete();
      ov_m     = 1'b0;
      un_m     = 1'b0;
      dout_m   = '0;
      model_ok = 1'b1;
    end else if (bus.en) begin
      r_ok = bus.rd_req && (q.size() > 0);
      w_ok = bus.wr_req && ((q.size() < DEPTH) || r_ok);
      if (r_ok) dout_m = q.pop_front();
      if (w_ok) q.push_back(bus.data_in);
      if (bus.wr_req && !w_ok) ov_m = 1'b1;
      if (bus.rd_req && !r_ok) un_m = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("usedw",        32'(bus.usedw),        32'(q.size()));
      chk("empty",        32'(bus.empty),        32'(q.size() == 0));
      chk("full",         32'(bus.full),         32'(q.size() == DEPTH));
      chk("almost_full",  32'(bus.almost_full),  32'(q.size() >= AF));
      chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
      chk("overflow",     32'(bus.overflow),     32'(ov_m));
      chk("underflow",    32'(bus.underflow),    32'(un_m));
`ifdef FIFO_FWFT_EN
      if (q.size() > 0) chk("data_out", 32'(bus.data_out), 32'(q[0]));
`else
      chk("data_out", 32'(bus.data_out), 32'(dout_m));
`endif
    end
  end

  task automatic step(input bit e, input bit w, input bit r, input logic [DW-1:0] d);
    bus.en      = e;
    bus.wr_req  = w;
    bus.rd_req  = r;
    bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pops one word and checks it where the active read mode presents it.
  task automatic read_chk(input string name, input logic [DW-1:0] exp);
`ifdef FIFO_FWFT_EN
    chk(name, 32'(bus.data_out), 32'(exp));
    step(1'b1, 1'b0, 1'b1, '0);
`else
    step(1'b1, 1'b0, 1'b1, '0);
    chk(name, 32'(bus.data_out), 32'(exp));
`endif
  endtask

  initial begin
    logic [DW-1:0] held;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;

    chk("rst_usedw",  32'(bus.usedw), 32'd0);
    chk("rst_empty",  32'(bus.empty), 32'd1);
    chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
    chk("rst_full",   32'(bus.full), 32'd0);
    chk("rst_ovf",    32'(bus.overflow), 32'd0);
    chk("rst_udf",    32'(bus.underflow), 32'd0);
    chk("rst_dout",   32'(bus.data_out), 32'd0);

    // Fill past full.
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b1, 1'b0, DW'(i));
      if (i == 3) chk("aempty_drop", 32'(bus.almost_empty), 32'd0);
      if (i == 5) chk("afull_below", 32'(bus.almost_full), 32'd0);
      if (i == 6) chk("afull_set",   32'(bus.almost_full), 32'd1);
      if (i == 8) begin
        chk("full_set",   32'(bus.full),  32'd1);
        chk("full_usedw", 32'(bus.usedw), 32'd8);
        chk("no_ovf_yet", 32'(bus.overflow), 32'd0);
      end
    end
    chk("ovf_set",   32'(bus.overflow), 32'd1);
    chk("ovf_usedw", 32'(bus.usedw), 32'd8);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    for (int i = 1; i <= 8; i++) read_chk("drain", DW'(i));
    chk("drained_empty", 32'(bus.empty), 32'd1);

    // Underflow, then write+read on empty.
    step(1'b1, 1'b0, 1'b1, '0);
    chk("udf_set",   32'(bus.underflow), 32'd1);
    chk("udf_usedw", 32'(bus.usedw), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("udf_dout_hold", 32'(bus.data_out), 32'h0008);
`endif
    step(1'b1, 1'b1, 1'b1, 16'h00AA);
    chk("wr_on_empty_usedw", 32'(bus.usedw), 32'd1);
    chk("wr_on_empty_empty", 32'(bus.empty), 32'd0);
    read_chk("aa_word", 16'h00AA);

    // Simultaneous read/write at full.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, DW'(16'h0010 + i));
    step(1'b1, 1'b1, 1'b1, 16'h0018);
    chk("simul_usedw", 32'(bus.usedw), 32'd8);
    chk("simul_full",  32'(bus.full), 32'd1);
    chk("simul_ovf",   32'(bus.overflow), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("simul_dout",  32'(bus.data_out), 32'h0010);
`endif
    for (int i = 1; i <= 8; i++) read_chk("wrap_read", DW'(16'h0010 + i));

    // Enable gating.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, DW'(16'h0030 + i));
    held = bus.data_out;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 16'hDEAD);
    chk("en_usedw", 32'(bus.usedw), 32'd3);
    chk("en_ovf",   32'(bus.overflow), 32'd0);
    chk("en_udf",   32'(bus.underflow), 32'd0);
    chk("en_dout",  32'(bus.data_out), 32'(held));
    for (int i = 0; i < 3; i++) read_chk("en_read", DW'(16'h0030 + i));

    // Two words then mid-stream reset.
    step(1'b1, 1'b1, 1'b0, 16'h1234);
    chk("two_empty", 32'(bus.empty), 32'd0);
`ifdef FIFO_FWFT_EN
    chk("fwft_head", 32'(bus.data_out), 32'h1234);
`endif
    step(1'b1, 1'b1, 1'b0, 16'h5678);
`ifdef FIFO_FWFT_EN
    chk("fwft_head_hold", 32'(bus.data_out), 32'h1234);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("fwft_next", 32'(bus.data_out), 32'h5678);
`else
    step(1'b1, 1'b0, 1'b1, '0);
    chk("reg_read", 32'(bus.data_out), 32'h1234);
`endif
    chk("two_usedw", 32'(bus.usedw), 32'd1);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 16'h9999);
    rst = 1'b0;
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_usedw", 32'(bus.usedw), 32'd0);

    // Randomized traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      bit wb;
      bit e;
      bit w;
      bit r;
      wb  = ((i / 300) % 2) == 0;
      rst = ($urandom_range(0, 199) == 0);
      e   = ($urandom_range(0, 9) != 0);
      w   = wb ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r   = wb ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(e, w, r, DW'($urandom));
    end
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
